// File: rtl/rpc_cmd_arbiter.sv
// rpc_cmd_arbiter: accepts one refresh, ZQ-calibration or direct command at a
// time from three valid/ready sources and registers it. The command is then
// presented to the command FSM, and no further grants are given until the FSM
// reports completion. Refresh and ZQC are gated by DRAM init completion. A
// wait counter promotes a starving direct command to top priority.
// Optional feature: define RPC_ARB_STATS_EN to build the per-source issued-
// command counters; otherwise the counter outputs are tied to zero.
module rpc_cmd_arbiter #(
  parameter int CMD_WIDTH  = 19,
  parameter int MAX_WAIT   = 16,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rpc_init_completed_i,
  input  logic                  ref_valid_i,
  output logic                  ref_ready_o,
  input  logic [CMD_WIDTH-1:0]  ref_cmd_i,
  input  logic                  zqc_valid_i,
  output logic                  zqc_ready_o,
  input  logic [CMD_WIDTH-1:0]  zqc_cmd_i,
  input  logic                  direct_valid_i,
  output logic                  direct_ready_o,
  input  logic [CMD_WIDTH-1:0]  direct_cmd_i,
  output logic                  cmd_valid_o,
  input  logic                  cmd_ready_i,
  output logic [CMD_WIDTH-1:0]  cmd_o,
  output logic [1:0]            cmd_src_o,
  input  logic                  cmd_done_i,
  output logic                  busy_o,
  output logic [STAT_WIDTH-1:0] ref_cnt_o,
  output logic [STAT_WIDTH-1:0] zqc_cnt_o,
  output logic [STAT_WIDTH-1:0] direct_cnt_o
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_REF  = 2'd1;
  localparam logic [1:0] SRC_ZQC  = 2'd2;
  localparam logic [1:0] SRC_DIR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [WAIT_W-1:0]     wait_cnt;
  logic                  starve;
  logic [1:0]            grant_src;
  logic                  grant;
  logic [CMD_WIDTH-1:0]  grant_cmd;

  assign starve = (wait_cnt >= WAIT_LIMIT);

  // State register; reset drops any captured command back to IDLE at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state: a grant starts a command, the FSM handshake moves to waiting,
  // and only a done pulse while waiting releases the arbiter.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (grant)       state_nxt = ISSUE;
      ISSUE:     if (cmd_ready_i) state_nxt = WAIT_DONE;
      WAIT_DONE: if (cmd_done_i)  state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Outputs and arbitration: readies are only raised in IDLE and depend on
  // valids, init and state, never on cmd_ready_i or cmd_done_i.
  always_comb begin
    grant_src = SRC_NONE;
    grant_cmd = '0;
    if (state == IDLE) begin
      if (direct_valid_i && starve)                  grant_src = SRC_DIR;
      else if (ref_valid_i && rpc_init_completed_i)  grant_src = SRC_REF;
      else if (zqc_valid_i && rpc_init_completed_i)  grant_src = SRC_ZQC;
      else if (direct_valid_i)                       grant_src = SRC_DIR;
    end
    case (grant_src)
      SRC_REF: grant_cmd = ref_cmd_i;
      SRC_ZQC: grant_cmd = zqc_cmd_i;
      SRC_DIR: grant_cmd = direct_cmd_i;
      default: grant_cmd = '0;
    endcase
    grant          = (grant_src != SRC_NONE);
    ref_ready_o    = (grant_src == SRC_REF);
    zqc_ready_o    = (grant_src == SRC_ZQC);
    direct_ready_o = (grant_src == SRC_DIR);
    cmd_valid_o    = (state == ISSUE);
    busy_o         = (state != IDLE);
  end

  // Capture the winning command and its source on the source handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_o     <= '0;
      cmd_src_o <= SRC_NONE;
    end else if (grant) begin
      cmd_o     <= grant_cmd;
      cmd_src_o <= grant_src;
    end
  end

  // Direct-command wait counter: counts lost IDLE arbitrations, saturating.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      if (!direct_valid_i || (grant_src == SRC_DIR)) wait_cnt <= '0;
      else if (!starve)                              wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

`ifdef RPC_ARB_STATS_EN
  logic                  dn_hs;
  logic [STAT_WIDTH-1:0] ref_cnt;
  logic [STAT_WIDTH-1:0] zqc_cnt;
  logic [STAT_WIDTH-1:0] direct_cnt;

  assign dn_hs = cmd_valid_o & cmd_ready_i;

  // Issued-command counters, one per source, wrapping on overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ref_cnt    <= '0;
      zqc_cnt    <= '0;
      direct_cnt <= '0;
    end else if (dn_hs) begin
      case (cmd_src_o)
        SRC_REF: ref_cnt    <= ref_cnt + STAT_WIDTH'(1);
        SRC_ZQC: zqc_cnt    <= zqc_cnt + STAT_WIDTH'(1);
        SRC_DIR: direct_cnt <= direct_cnt + STAT_WIDTH'(1);
        default: ;
      endcase
    end
  end

  assign ref_cnt_o    = ref_cnt;
  assign zqc_cnt_o    = zqc_cnt;
  assign direct_cnt_o = direct_cnt;
`else
  assign ref_cnt_o    = '0;
  assign zqc_cnt_o    = '0;
  assign direct_cnt_o = '0;
`endif

endmodule

// File: doc/rpc_cmd_arbiter.md
# rpc_cmd_arbiter

Receiving end of the refresh, ZQ-calibration and direct-command streams produced by the RPC configuration path. The block accepts one command at a time from the three valid/ready sources and registers it. It presents the command to the command FSM, then holds off further grants until the FSM signals completion. Refresh and ZQC are gated until DRAM initialization completes, and a wait counter prevents starvation of direct commands.

## Interface
- CMD_WIDTH, 19, command word width; must match the timer and config-register output width.
- MAX_WAIT, 16, cycles a pending direct command may lose arbitration before it is promoted to top priority; must be ≥1.
- STAT_WIDTH, 16, width of the statistics counters.
- clk_i  in  1  single clock.
- rst_ni  in  1  asynchronous active-low reset.
- rpc_init_completed_i  in  1  level; enables the refresh and ZQC sources.
- ref_valid_i / ref_ready_o / ref_cmd_i  in/out/in  1/1/CMD_WIDTH  refresh source.
- zqc_valid_i / zqc_ready_o / zqc_cmd_i  in/out/in  1/1/CMD_WIDTH  ZQC source.
- direct_valid_i / direct_ready_o / direct_cmd_i  in/out/in  1/1/CMD_WIDTH  direct-command source.
- cmd_valid_o  out  1  command presented to the FSM.
- cmd_ready_i  in  1  FSM accepts the command.
- cmd_o  out  CMD_WIDTH  registered command.
- cmd_src_o  out  2  command source: 0 none, 1 ref, 2 zqc, 3 direct.
- cmd_done_i  in  1  one-cycle pulse from the FSM when the accepted command has finished on the DRAM.
- busy_o  out  1  high in any state other than IDLE.
- ref_cnt_o / zqc_cnt_o / direct_cnt_o  out  STAT_WIDTH each  issued-command counters (see Configuration).

## Operation
- The FSM has three states: IDLE, ISSUE and WAIT_DONE. Reset enters IDLE.
- **IDLE**
  - Eligible requests are ref_valid_i and zqc_valid_i (each only when rpc_init_completed_i=1) and direct_valid_i (always eligible).
  - Priority is ref > zqc > direct.
  - When the wait counter is ≥ MAX_WAIT, direct has the highest priority.
  - The winner's ready_o is asserted combinationally in the same cycle; only one ready_o is high per cycle.
  - On the handshake, cmd_o and cmd_src_o are captured and the FSM moves to ISSUE.
- **ISSUE**
  - cmd_valid_o=1. cmd_o and cmd_src_o stay stable until cmd_ready_i=1.
  - On the handshake, the FSM moves to WAIT_DONE. All source ready_o are 0.
- **WAIT_DONE**
  - cmd_valid_o=0. The FSM returns to IDLE on cmd_done_i=1.
  - cmd_done_i is ignored in IDLE and ISSUE.
  - cmd_src_o holds its value until the next grant.
- **Wait counter** (width $clog2(MAX_WAIT+1))
  - Increments, saturating at MAX_WAIT, in each IDLE cycle where direct_valid_i=1 and direct is not granted.
  - Clears when direct is granted or when direct_valid_i=0.
  - Holds its value in ISSUE and WAIT_DONE.
- If rpc_init_completed_i falls while in ISSUE or WAIT_DONE, the captured command still completes normally; gating applies only at grant time.
- A source that drops valid before being granted is simply not considered. Sources are not required to hold valid.

## Timing
- Reset values: cmd_valid_o=0, cmd_o=0, cmd_src_o=0, busy_o=0, all ready_o=0, wait counter=0, statistics counters=0.
- The source handshake in cycle N produces cmd_valid_o=1 in cycle N+1.
- The earliest next grant is the cycle after cmd_done_i is sampled. The minimum spacing between source handshakes is 3 cycles (grant, ISSUE, done).
- ready_o depends combinationally on the valid inputs, rpc_init_completed_i and state. There is no combinational path from cmd_ready_i or cmd_done_i to any source ready_o.
- Asserting rst_ni mid-operation discards the captured command and returns all outputs to their reset values immediately.

## Configuration
- RPC_ARB_STATS_EN defined:
  - Each counter increments by 1 on a downstream handshake (cmd_valid_o & cmd_ready_i) for its source.
  - Counters wrap modulo 2^STAT_WIDTH.
- RPC_ARB_STATS_EN not defined: the counter outputs are tied to 0 and no counter registers exist.

## Test plan
- **Init gating:** rpc_init_completed_i=0, ref_valid_i=1 and zqc_valid_i=1 for 10 cycles → ref_ready_o=zqc_ready_o=0 and cmd_valid_o=0. Then set rpc_init_completed_i=1 → ref is granted in that cycle and cmd_src_o=1 the next cycle.
- **Priority:** ref, zqc and direct all valid in IDLE, with ref_cmd_i=19'h00001, zqc_cmd_i=19'h00002 and direct_cmd_i=19'h00003 → commands issue in order 1, 2, 3, with cmd_done_i pulsed after each.
- **Back-pressure:** cmd_ready_i=0 for 5 cycles while in ISSUE → cmd_o holds its value, no new source ready_o is asserted, and busy_o=1.
- **Starvation:** MAX_WAIT=4, ref_valid_i permanently 1, direct_valid_i=1, each command completed immediately → direct is granted no later than the 5th IDLE arbitration, after which the wait counter is 0.
- **Done handling:** a cmd_done_i pulse in IDLE or ISSUE → no state change. A pulse in WAIT_DONE → the FSM is in IDLE the next cycle.
- **Reset and stats:** rst_ni asserted while in ISSUE → cmd_valid_o=0 immediately. With RPC_ARB_STATS_EN defined and STAT_WIDTH=4, 17 ref commands issued → ref_cnt_o=1.
